// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
//   Turns one raw, bouncing push-button into a clean debounced level and
//   single-cycle press / repeat / release strobes. It also keeps a modulo-
//   P_FIELDS index of the next operand-entry field, which advances on every
//   step (press or repeat) strobe.
//
// Ports
//   I_CLK            in   system clock, rising edge
//   I_NRESET         in   asynchronous active-low reset
//   I_BUTTON         in   raw asynchronous button
//   I_CLEAR          in   synchronous clear of O_FIELD (beats a step)
//   O_LEVEL          out  debounced pressed level
//   O_PRESS_PULSE    out  one-cycle strobe on an accepted press
//   O_REPEAT_PULSE   out  one-cycle strobe on each auto-repeat
//   O_RELEASE_PULSE  out  one-cycle strobe on an accepted release
//   O_STEP_PULSE     out  press | repeat strobe for the downstream FSM
//   O_FIELD          out  index of the next field, 0..P_FIELDS-1
// -----------------------------------------------------------------------------
module button_debouncer #(
  parameter bit          P_ACTIVE_LOW           = 1'b1,
  parameter int unsigned P_DEBOUNCE_CYCLES      = 500000,
  parameter bit          P_REPEAT_EN            = 1'b0,
  parameter int unsigned P_REPEAT_DELAY_CYCLES  = 25000000,
  parameter int unsigned P_REPEAT_PERIOD_CYCLES = 5000000,
  parameter int unsigned P_FIELDS               = 5
) (
  input  logic       I_CLK,
  input  logic       I_NRESET,
  input  logic       I_BUTTON,
  input  logic       I_CLEAR,
  output logic       O_LEVEL,
  output logic       O_PRESS_PULSE,
  output logic       O_REPEAT_PULSE,
  output logic       O_RELEASE_PULSE,
  output logic       O_STEP_PULSE,
  output logic [2:0] O_FIELD
);

  localparam int unsigned CNT_W    = $clog2(P_DEBOUNCE_CYCLES + 1);
  localparam int unsigned RPT_MAX  = (P_REPEAT_DELAY_CYCLES > P_REPEAT_PERIOD_CYCLES) ?
                                     P_REPEAT_DELAY_CYCLES : P_REPEAT_PERIOD_CYCLES;
  localparam int unsigned RCNT_W   = $clog2(RPT_MAX + 1);
  localparam int unsigned FIELD_W  = 3;

  // Raw pin level while the button is released.
  localparam logic                REL_RAW    = P_ACTIVE_LOW;
  localparam logic [CNT_W-1:0]    DEB_LAST   = CNT_W'(P_DEBOUNCE_CYCLES - 1);
  localparam logic [RCNT_W-1:0]   RPT_FIRST  = RCNT_W'(P_REPEAT_DELAY_CYCLES - 1);
  localparam logic [RCNT_W-1:0]   RPT_NEXT   = RCNT_W'(P_REPEAT_PERIOD_CYCLES - 1);
  localparam logic [FIELD_W-1:0]  FIELD_LAST = FIELD_W'(P_FIELDS - 1);

  localparam logic [1:0] ST_REL   = 2'd0;
  localparam logic [1:0] ST_PWAIT = 2'd1;
  localparam logic [1:0] ST_PRS   = 2'd2;
  localparam logic [1:0] ST_RWAIT = 2'd3;

  logic                sync1_q, sync2_q;
  logic                pressed_c;
  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [RCNT_W-1:0]   rcnt_q, rcnt_d;
  logic                rflag_q, rflag_d;
  logic                level_q, level_d;
  logic                press_q, press_d;
  logic                repeat_q, repeat_d;
  logic                release_q, release_d;
  logic                step_q, step_d;
  logic [FIELD_W-1:0]  field_q, field_d;

  // Two-flop synchronizer, reset to the released level so reset exit never looks like a press.
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      sync1_q <= REL_RAW;
      sync2_q <= REL_RAW;
    end else begin
      sync1_q <= I_BUTTON;
      sync2_q <= sync1_q;
    end
  end

  assign pressed_c = P_ACTIVE_LOW ? ~sync2_q : sync2_q;

  // State and output registers.
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      state_q   <= ST_REL;
      cnt_q     <= '0;
      rcnt_q    <= '0;
      rflag_q   <= 1'b0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      repeat_q  <= 1'b0;
      release_q <= 1'b0;
      step_q    <= 1'b0;
      field_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rcnt_q    <= rcnt_d;
      rflag_q   <= rflag_d;
      level_q   <= level_d;
      press_q   <= press_d;
      repeat_q  <= repeat_d;
      release_q <= release_d;
      step_q    <= step_d;
      field_q   <= field_d;
    end
  end

  // Debounce / auto-repeat next-state and strobe logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rcnt_d    = rcnt_q;
    rflag_d   = rflag_q;
    press_d   = 1'b0;
    repeat_d  = 1'b0;
    release_d = 1'b0;

    case (state_q)
      ST_REL: begin
        if (pressed_c) begin
          state_d = ST_PWAIT;
          cnt_d   = '0;
        end
      end
      ST_PWAIT: begin
        if (!pressed_c) begin
          state_d = ST_REL;
        end else if (cnt_q == DEB_LAST) begin
          state_d = ST_PRS;
          press_d = 1'b1;
          rcnt_d  = '0;
          rflag_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_PRS: begin
        if (!pressed_c) begin
          state_d = ST_RWAIT;
          cnt_d   = '0;
        end else if (P_REPEAT_EN) begin
          // First repeat waits the long delay, later ones the short period.
          if (rcnt_q == (rflag_q ? RPT_NEXT : RPT_FIRST)) begin
            repeat_d = 1'b1;
            rcnt_d   = '0;
            rflag_d  = 1'b1;
          end else begin
            rcnt_d = rcnt_q + RCNT_W'(1);
          end
        end
      end
      ST_RWAIT: begin
        // rcnt is left untouched here so a release glitch does not restart repeat timing.
        if (pressed_c) begin
          state_d = ST_PRS;
        end else if (cnt_q == DEB_LAST) begin
          state_d   = ST_REL;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_REL;
      end
    endcase
  end

  // Registered level, step strobe and field index follow the next state.
  always_comb begin
    level_d = (state_d == ST_PRS) || (state_d == ST_RWAIT);
    step_d  = press_d | repeat_d;
    field_d = field_q;
    if (I_CLEAR) begin
      field_d = '0;
    end else if (step_d) begin
      field_d = (field_q == FIELD_LAST) ? '0 : field_q + FIELD_W'(1);
    end
  end

  assign O_LEVEL         = level_q;
  assign O_PRESS_PULSE   = press_q;
  assign O_REPEAT_PULSE  = repeat_q;
  assign O_RELEASE_PULSE = release_q;
  assign O_STEP_PULSE    = step_q;
  assign O_FIELD         = field_q;

endmodule

// File: tb/tb_button_debouncer.sv
// -----------------------------------------------------------------------------
// tb_button_debouncer
//   Directed bench for button_debouncer with short timing parameters. Expected
//   strobes (kind, cycle, field after) are queued when stimulus is applied and
//   matched against the strobes the DUT produces, sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_button_debouncer;

  localparam int unsigned DEB    = 4;
  localparam int unsigned DELAY  = 8;
  localparam int unsigned PERIOD = 3;
  localparam int unsigned FIELDS = 5;

  localparam int K_PRESS   = 0;
  localparam int K_REPEAT  = 1;
  localparam int K_RELEASE = 2;

  typedef struct {
    int    kind;
    int    at;
    int    field;
    string tag;
  } ev_t;

  logic       clk;
  logic       rst_n;
  logic       button;
  logic       clear;
  logic       level;
  logic       press_p;
  logic       repeat_p;
  logic       release_p;
  logic       step_p;
  logic [2:0] field;

  ev_t sb[$];
  int  cyc;
  int  errors;
  int  checks;

  button_debouncer #(
    .P_ACTIVE_LOW           (1'b1),
    .P_DEBOUNCE_CYCLES      (DEB),
    .P_REPEAT_EN            (1'b1),
    .P_REPEAT_DELAY_CYCLES  (DELAY),
    .P_REPEAT_PERIOD_CYCLES (PERIOD),
    .P_FIELDS               (FIELDS)
  ) dut (
    .I_CLK           (clk),
    .I_NRESET        (rst_n),
    .I_BUTTON        (button),
    .I_CLEAR         (clear),
    .O_LEVEL         (level),
    .O_PRESS_PULSE   (press_p),
    .O_REPEAT_PULSE  (repeat_p),
    .O_RELEASE_PULSE (release_p),
    .O_STEP_PULSE    (step_p),
    .O_FIELD         (field)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic expect_ev(input int kind, input int at, input int fld, input string tag);
    ev_t e;
    e.kind  = kind;
    e.at    = at;
    e.field = fld;
    e.tag   = tag;
    sb.push_back(e);
  endtask

  // Match any strobe seen this cycle against the scoreboard; flag overdue entries.
  task automatic monitor();
    int   n;
    int   kind;
    ev_t  e;
    while (sb.size() != 0 && sb[0].at < cyc) begin
      e = sb.pop_front();
      check({"missed_", e.tag}, cyc, e.at);
    end
    n = int'(press_p) + int'(repeat_p) + int'(release_p);
    if (n > 1) check("strobe_onehot", n, 1);
    if (n != 0) begin
      kind = press_p ? K_PRESS : (repeat_p ? K_REPEAT : K_RELEASE);
      if (sb.size() == 0) begin
        check("unexpected_strobe_kind", kind, -1);
      end else begin
        e = sb.pop_front();
        check({e.tag, "_kind"},  kind,        e.kind);
        check({e.tag, "_cycle"}, cyc,         e.at);
        check({e.tag, "_field"}, int'(field), e.field);
        check({e.tag, "_step"},  int'(step_p), (e.kind == K_RELEASE) ? 0 : 1);
      end
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      monitor();
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_level"},   int'(level),     0);
    check({tag, "_press"},   int'(press_p),   0);
    check({tag, "_repeat"},  int'(repeat_p),  0);
    check({tag, "_release"}, int'(release_p), 0);
    check({tag, "_step"},    int'(step_p),    0);
    check({tag, "_field"},   int'(field),     0);
  endtask

  initial begin
    int t;
    int u;
    int v;
    int w;
    int x;
    cyc    = 0;
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    button = 1'b1;
    clear  = 1'b0;

    // Reset state, then reset exit with button released.
    tick(3);
    check_idle("in_reset");
    rst_n = 1'b1;
    tick(3);
    check_idle("after_reset");

    // Clean press, then hold with auto-repeat and field wrap.
    t = cyc;
    button = 1'b0;
    expect_ev(K_PRESS,  t + 7,  1, "press1");
    expect_ev(K_REPEAT, t + 15, 2, "rep_first");
    expect_ev(K_REPEAT, t + 18, 3, "rep2");
    expect_ev(K_REPEAT, t + 21, 4, "rep3");
    expect_ev(K_REPEAT, t + 24, 0, "rep_wrap");
    tick(6);
    check("level_before_press", int'(level), 0);
    tick(1);
    check("level_at_press", int'(level), 1);
    tick(17);
    check("field_wrapped", int'(field), 0);

    // Two-cycle release glitch: level stays, repeat timing resumes from where it froze.
    button = 1'b1;
    tick(2);
    button = 1'b0;
    expect_ev(K_REPEAT, t + 30, 1, "rep_after_glitch");
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("level_through_glitch", int'(level), 1);
    end

    // Full release.
    button = 1'b1;
    expect_ev(K_RELEASE, t + 37, 1, "release1");
    tick(6);
    check("level_before_release", int'(level), 1);
    tick(1);
    check("level_after_release", int'(level), 0);

    // Bounce: 2-cycle toggles never qualify.
    for (int i = 0; i < 5; i++) begin
      button = 1'b0;
      tick(2);
      check("bounce_level_lo", int'(level), 0);
      button = 1'b1;
      tick(2);
      check("bounce_level_hi", int'(level), 0);
    end
    tick(10);
    check("bounce_field_kept", int'(field), 1);

    // Clear coinciding with a step edge while the field is 3.
    u = cyc;
    button = 1'b0;
    expect_ev(K_PRESS,  u + 7,  2, "press2");
    expect_ev(K_REPEAT, u + 15, 3, "rep_to3");
    expect_ev(K_REPEAT, u + 18, 0, "clear_beats_step");
    expect_ev(K_REPEAT, u + 21, 1, "rep_after_clear");
    tick(17);
    check("field_before_clear", int'(field), 3);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("field_cleared", int'(field), 0);
    tick(3);
    button = 1'b1;
    expect_ev(K_RELEASE, u + 28, 1, "release2");
    tick(10);

    // Reset during PWAIT, button held through reset exit.
    v = cyc;
    button = 1'b0;
    tick(4);
    check("pwait_level", int'(level), 0);
    rst_n = 1'b0;
    #1;
    check_idle("async_reset");
    tick(2);
    check_idle("held_reset");
    w = cyc;
    rst_n = 1'b1;
    expect_ev(K_PRESS, w + 7, 1, "press_after_reset");
    tick(6);
    check("level_before_reset_press", int'(level), 0);
    tick(1);
    check("level_reset_press", int'(level), 1);
    x = cyc;
    button = 1'b1;
    expect_ev(K_RELEASE, x + 7, 1, "release3");
    tick(10);

    check("scoreboard_drained", sb.size(), 0);
    if (v < 0) check("unused_v", v, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
